// File: rtl/y86_boot_mem_if.sv
// Loader stream and core memory bus between y86_boot_mem and its neighbours.
interface y86_boot_mem_if #(
  parameter int unsigned ADDR_W = 10
);
  // Loader byte stream
  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_err;
  logic [ADDR_W:0]   boot_bytes;
  // Core side
  logic              cpu_rst;
  logic [31:0]       bus_A;
  logic              bus_RE;
  logic              bus_WE;
  logic [31:0]       bus_out;
  logic [31:0]       bus_in;
  logic              bus_err;

  // Memory block side
  modport slave (
    input  ld_valid, ld_data, ld_last, bus_A, bus_RE, bus_WE, bus_out,
    output ld_ready, ld_err, boot_bytes, cpu_rst, bus_in, bus_err
  );

  // Loader and core side
  modport master (
    output ld_valid, ld_data, ld_last, bus_A, bus_RE, bus_WE, bus_out,
    input  ld_ready, ld_err, boot_bytes, cpu_rst, bus_in, bus_err
  );
endinterface

// File: rtl/y86_boot_mem.sv
// Unified byte-addressed memory for the y86 core with a streaming boot loader.
// LOAD accepts the image byte by byte, HOLD keeps the core in reset for two
// more edges, RUN serves zero-latency reads and one-cycle writes.
module y86_boot_mem #(
  parameter int unsigned ADDR_W = 10
) (
  input logic            clk,
  input logic            rst,
  y86_boot_mem_if.slave  mem_if
);

  localparam int unsigned Depth = 1 << ADDR_W;

  typedef enum logic [1:0] {StLoad, StHold, StRun} state_e;

  state_e            state_q, state_d;
  logic              hold_q, hold_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ld_err_q, ld_err_d;
  logic              bus_err_q, bus_err_d;
  logic              ld_ready_q, ld_ready_d;
  logic              cpu_rst_q, cpu_rst_d;

  logic [7:0]        mem_q [Depth];

  logic              ld_xfer;
  logic              ld_full;
  logic              ld_we;
  logic              in_run;
  logic              bus_oor;
  logic              bus_we;
  logic [ADDR_W-1:0] byte_addr [4];
  logic [31:0]       rd_word;

  // Handshake and address decode
  always_comb begin
    ld_xfer = (state_q == StLoad) && mem_if.ld_valid && ld_ready_q;
    // Top count bit set means every location has been filled
    ld_full = cnt_q[ADDR_W];
    ld_we   = ld_xfer && !ld_full;
    in_run  = (state_q == StRun);
    bus_oor = |(mem_if.bus_A >> ADDR_W);
    bus_we  = in_run && mem_if.bus_WE && !bus_oor;
  end

  // Byte lane addresses wrap modulo the memory size, so unaligned words work
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      byte_addr[i] = mem_if.bus_A[ADDR_W-1:0] + ADDR_W'(i);
    end
  end

  // Little-endian combinational read; zero outside RUN or out of range
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++) begin
      rd_word[8*i +: 8] = mem_q[byte_addr[i]];
    end
    mem_if.bus_in = (in_run && mem_if.bus_RE && !bus_oor) ? rd_word : 32'h0;
  end

  // Next-state for the FSM, load counter and sticky error flags
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    ld_err_d  = ld_err_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      StLoad: begin
        if (ld_xfer) begin
          if (ld_full) begin
            ld_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          // A dropped overflow byte can still terminate the image
          if (mem_if.ld_last) begin
            state_d = StHold;
            hold_d  = 1'b0;
          end
        end
      end
      StHold: begin
        hold_d = 1'b1;
        if (hold_q) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if ((mem_if.bus_RE || mem_if.bus_WE) && bus_oor) begin
          bus_err_d = 1'b1;
        end
      end
      default: state_d = StLoad;
    endcase
    // Outputs are registered from the next state so they change with it
    ld_ready_d = (state_d == StLoad);
    cpu_rst_d  = (state_d != StRun);
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StLoad;
      hold_q     <= 1'b0;
      cnt_q      <= '0;
      ld_err_q   <= 1'b0;
      bus_err_q  <= 1'b0;
      ld_ready_q <= 1'b1;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      ld_err_q   <= ld_err_d;
      bus_err_q  <= bus_err_d;
      ld_ready_q <= ld_ready_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  // Storage array; deliberately untouched by reset so an image survives it
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem_q[cnt_q[ADDR_W-1:0]] <= mem_if.ld_data;
    end
    if (bus_we) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[byte_addr[i]] <= mem_if.bus_out[8*i +: 8];
      end
    end
  end

  // Registered outputs
  always_comb begin
    mem_if.ld_ready   = ld_ready_q;
    mem_if.ld_err     = ld_err_q;
    mem_if.boot_bytes = cnt_q;
    mem_if.cpu_rst    = cpu_rst_q;
    mem_if.bus_err    = bus_err_q;
  end

endmodule

// File: tb/tb_y86_boot_mem.sv
// Directed bench for y86_boot_mem: one 1 KiB instance and one 16-byte instance.
module tb_y86_boot_mem;

  logic clk = 1'b0;
  logic rst10;
  logic rst4;
  int   passed = 0;
  int   total  = 0;
  logic [7:0] img [$];

  always #5 clk = ~clk;

  y86_boot_mem_if #(.ADDR_W(10)) if10 ();
  y86_boot_mem_if #(.ADDR_W(4))  if4 ();

  y86_boot_mem #(.ADDR_W(10)) u_dut10 (.clk(clk), .rst(rst10), .mem_if(if10));
  y86_boot_mem #(.ADDR_W(4))  u_dut4  (.clk(clk), .rst(rst4),  .mem_if(if4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load10();
    foreach (img[i]) begin
      if10.ld_valid = 1'b1;
      if10.ld_data  = img[i];
      if10.ld_last  = (i == img.size() - 1);
      tick();
    end
    if10.ld_valid = 1'b0;
    if10.ld_last  = 1'b0;
  endtask

  task automatic load4();
    foreach (img[i]) begin
      if4.ld_valid = 1'b1;
      if4.ld_data  = img[i];
      if4.ld_last  = (i == img.size() - 1);
      tick();
    end
    if4.ld_valid = 1'b0;
    if4.ld_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst10 = 1'b0;
    if10.bus_RE = 1'b1;
    tick();
    tick();
    rst10 = 1'b1;
    #1;
    total++; if (if10.ld_ready !== 1'b1) $display("FAIL rst_ld_ready: got %b want 1", if10.ld_ready); else passed++;
    total++; if (if10.cpu_rst !== 1'b1) $display("FAIL rst_cpu_rst: got %b want 1", if10.cpu_rst); else passed++;
    total++; if (if10.bus_in !== 32'h0) $display("FAIL rst_bus_in: got %h want 0", if10.bus_in); else passed++;
    total++; if (if10.ld_err !== 1'b0) $display("FAIL rst_ld_err: got %b want 0", if10.ld_err); else passed++;
    total++; if (if10.bus_err !== 1'b0) $display("FAIL rst_bus_err: got %b want 0", if10.bus_err); else passed++;
    total++; if (if10.boot_bytes !== 11'd0) $display("FAIL rst_boot_bytes: got %0d want 0", if10.boot_bytes); else passed++;
    if10.bus_RE = 1'b0;
  endtask

  task automatic test_load();
    img = '{8'h8B, 8'h45, 8'h04, 8'h00};
    load10();
    // now just after edge N (last transfer)
    total++; if (if10.boot_bytes !== 11'd4) $display("FAIL load_boot_bytes: got %0d want 4", if10.boot_bytes); else passed++;
    total++; if (if10.ld_ready !== 1'b0) $display("FAIL hold_ld_ready: got %b want 0", if10.ld_ready); else passed++;
    total++; if (if10.cpu_rst !== 1'b1) $display("FAIL hold_cpu_rst_n: got %b want 1", if10.cpu_rst); else passed++;
    tick();
    total++; if (if10.cpu_rst !== 1'b1) $display("FAIL hold_cpu_rst_n1: got %b want 1", if10.cpu_rst); else passed++;
    tick();
    total++; if (if10.cpu_rst !== 1'b0) $display("FAIL run_cpu_rst_n2: got %b want 0", if10.cpu_rst); else passed++;
    if10.bus_A  = 32'h0;
    if10.bus_RE = 1'b1;
    #1;
    total++; if (if10.bus_in !== 32'h0004458B) $display("FAIL load_read0: got %h want 0004458b", if10.bus_in); else passed++;
    if10.bus_RE = 1'b0;
    #1;
    total++; if (if10.bus_in !== 32'h0) $display("FAIL read_no_re: got %h want 0", if10.bus_in); else passed++;
  endtask

  task automatic test_write();
    if10.bus_WE  = 1'b1;
    if10.bus_A   = 32'h14;
    if10.bus_out = 32'h000000A5;
    tick();
    if10.bus_A   = 32'h10;
    if10.bus_out = 32'hDEADBEEF;
    tick();
    if10.bus_WE = 1'b0;
    if10.bus_RE = 1'b1;
    if10.bus_A  = 32'h11;
    #1;
    total++; if (if10.bus_in !== 32'hA5DEADBE) $display("FAIL write_unaligned: got %h want a5deadbe", if10.bus_in); else passed++;
    // simultaneous read and write: old data now, new data after the edge
    if10.bus_A   = 32'h0;
    if10.bus_WE  = 1'b1;
    if10.bus_out = 32'h11223344;
    #1;
    total++; if (if10.bus_in !== 32'h0004458B) $display("FAIL rw_old_data: got %h want 0004458b", if10.bus_in); else passed++;
    tick();
    if10.bus_WE = 1'b0;
    #1;
    total++; if (if10.bus_in !== 32'h11223344) $display("FAIL rw_new_data: got %h want 11223344", if10.bus_in); else passed++;
    if10.bus_RE = 1'b0;
  endtask

  task automatic test_out_of_range();
    if10.bus_RE = 1'b1;
    if10.bus_A  = 32'h400;
    #1;
    total++; if (if10.bus_in !== 32'h0) $display("FAIL oor_read: got %h want 0", if10.bus_in); else passed++;
    total++; if (if10.bus_err !== 1'b0) $display("FAIL oor_err_before: got %b want 0", if10.bus_err); else passed++;
    tick();
    total++; if (if10.bus_err !== 1'b1) $display("FAIL oor_err_set: got %b want 1", if10.bus_err); else passed++;
    if10.bus_RE  = 1'b0;
    if10.bus_WE  = 1'b1;
    if10.bus_out = 32'hCAFEF00D;
    tick();
    if10.bus_WE = 1'b0;
    if10.bus_RE = 1'b1;
    if10.bus_A  = 32'h0;
    #1;
    total++; if (if10.bus_in !== 32'h11223344) $display("FAIL oor_write_blocked: got %h want 11223344", if10.bus_in); else passed++;
    total++; if (if10.bus_err !== 1'b1) $display("FAIL oor_err_sticky: got %b want 1", if10.bus_err); else passed++;
    if10.bus_RE = 1'b0;
  endtask

  task automatic test_reset_in_run();
    rst10 = 1'b0;
    tick();
    rst10 = 1'b1;
    if10.bus_RE = 1'b1;
    if10.bus_A  = 32'h0;
    #1;
    total++; if (if10.cpu_rst !== 1'b1) $display("FAIL rerst_cpu_rst: got %b want 1", if10.cpu_rst); else passed++;
    total++; if (if10.ld_ready !== 1'b1) $display("FAIL rerst_ld_ready: got %b want 1", if10.ld_ready); else passed++;
    total++; if (if10.boot_bytes !== 11'd0) $display("FAIL rerst_boot_bytes: got %0d want 0", if10.boot_bytes); else passed++;
    total++; if (if10.bus_err !== 1'b0) $display("FAIL rerst_bus_err: got %b want 0", if10.bus_err); else passed++;
    total++; if (if10.bus_in !== 32'h0) $display("FAIL rerst_bus_in_load: got %h want 0", if10.bus_in); else passed++;
    img = '{8'h77};
    load10();
    total++; if (if10.boot_bytes !== 11'd1) $display("FAIL reload_boot_bytes: got %0d want 1", if10.boot_bytes); else passed++;
    tick();
    tick();
    #1;
    total++; if (if10.bus_in !== 32'h11223377) $display("FAIL reload_read0: got %h want 11223377", if10.bus_in); else passed++;
    if10.bus_A = 32'h10;
    #1;
    total++; if (if10.bus_in !== 32'hDEADBEEF) $display("FAIL reload_keep: got %h want deadbeef", if10.bus_in); else passed++;
    if10.bus_RE = 1'b0;
  endtask

  task automatic test_overflow_wrap();
    rst4 = 1'b0;
    tick();
    rst4 = 1'b1;
    img = {};
    for (int i = 0; i < 18; i++) img.push_back(8'hA0 + 8'(i));
    load4();
    total++; if (if4.ld_err !== 1'b1) $display("FAIL ovf_ld_err: got %b want 1", if4.ld_err); else passed++;
    total++; if (if4.boot_bytes !== 5'd16) $display("FAIL ovf_boot_bytes: got %0d want 16", if4.boot_bytes); else passed++;
    tick();
    tick();
    total++; if (if4.cpu_rst !== 1'b0) $display("FAIL ovf_run: got %b want 0", if4.cpu_rst); else passed++;
    if4.bus_RE = 1'b1;
    if4.bus_A  = 32'h0;
    #1;
    total++; if (if4.bus_in !== 32'hA3A2A1A0) $display("FAIL ovf_read0: got %h want a3a2a1a0", if4.bus_in); else passed++;
    if4.bus_A = 32'hC;
    #1;
    total++; if (if4.bus_in !== 32'hAFAEADAC) $display("FAIL ovf_readc: got %h want afaeadac", if4.bus_in); else passed++;
    if4.bus_A = 32'hE;
    #1;
    total++; if (if4.bus_in !== 32'hA1A0AFAE) $display("FAIL wrap_read: got %h want a1a0afae", if4.bus_in); else passed++;
    if4.bus_RE  = 1'b0;
    if4.bus_WE  = 1'b1;
    if4.bus_A   = 32'hF;
    if4.bus_out = 32'h44332211;
    tick();
    if4.bus_WE = 1'b0;
    if4.bus_RE = 1'b1;
    if4.bus_A  = 32'hE;
    #1;
    total++; if (if4.bus_in !== 32'h332211AE) $display("FAIL wrap_write_e: got %h want 332211ae", if4.bus_in); else passed++;
    if4.bus_A = 32'h0;
    #1;
    total++; if (if4.bus_in !== 32'hA3443322) $display("FAIL wrap_write_0: got %h want a3443322", if4.bus_in); else passed++;
    if4.bus_RE = 1'b0;
  endtask

  initial begin
    rst10 = 1'b0;
    rst4  = 1'b0;
    if10.ld_valid = 1'b0; if10.ld_data = 8'h0; if10.ld_last = 1'b0;
    if10.bus_A = 32'h0; if10.bus_RE = 1'b0; if10.bus_WE = 1'b0; if10.bus_out = 32'h0;
    if4.ld_valid = 1'b0; if4.ld_data = 8'h0; if4.ld_last = 1'b0;
    if4.bus_A = 32'h0; if4.bus_RE = 1'b0; if4.bus_WE = 1'b0; if4.bus_out = 32'h0;
    test_reset();
    test_load();
    test_write();
    test_out_of_range();
    test_reset_in_run();
    test_overflow_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
